// File: rtl/lfsr_prng.sv
// Parametrised Fibonacci/Galois LFSR with seed load, zero-seed recovery
// and a valid/ready word packer for the generated bit stream.
module lfsr_prng #(
  parameter int              WIDTH = 32,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(32'h8020_0003),
  parameter logic [WIDTH-1:0] SEED = WIDTH'(1),
  parameter bit              MODE  = 1'b0,
  parameter int              OUT_W = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             enable_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] seed_i,
  output logic [WIDTH-1:0] state_o,
  output logic             bit_o,
  output logic [OUT_W-1:0] word_o,
  output logic             word_valid_o,
  input  logic             word_ready_i,
  output logic             stall_o,
  output logic             lockup_o
);

  localparam int CW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(OUT_W - 1);
  localparam logic [WIDTH-1:0] SEED_NZ =
    (SEED == '0) ? WIDTH'(1) : SEED;

  logic [WIDTH-1:0] state_q, state_d;
  logic [OUT_W-1:0] coll_q, coll_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [OUT_W-1:0] word_q, word_d;
  logic             valid_q, valid_d;
  logic             lock_q, lock_d;

  logic [WIDTH-1:0] next_w;
  logic             bit_w;
  logic [OUT_W:0]   ext_w;
  logic             last_w;
  logic             stall_w;
  logic             step_w;
  logic             xfer_w;

  always_comb begin
    if (MODE) begin
      next_w = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
      bit_w  = state_q[0];
    end else begin
      next_w = {state_q[WIDTH-2:0], ^(state_q & TAPS)};
      bit_w  = state_q[WIDTH-1];
    end
  end

  // first bit of a word ends up in the MSB after OUT_W shifts
  assign ext_w   = {coll_q, bit_w};
  assign last_w  = (cnt_q == LAST);
  assign stall_w = valid_q & ~word_ready_i & last_w;
  assign step_w  = enable_i & ~load_i & ~stall_w;
  assign xfer_w  = valid_q & word_ready_i;

  always_comb begin
    state_d = state_q;
    coll_d  = coll_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    valid_d = valid_q;
    lock_d  = 1'b0;
    if (load_i) begin
      lock_d  = (seed_i == '0);
      state_d = (seed_i == '0) ? SEED_NZ : seed_i;
      coll_d  = '0;
      cnt_d   = '0;
    end else if (step_w) begin
      state_d = next_w;
      coll_d  = ext_w[OUT_W-1:0];
      cnt_d   = last_w ? '0 : cnt_q + CW'(1);
    end
    // a completing word wins over a transfer: no bubble
    if (step_w && last_w) begin
      word_d  = ext_w[OUT_W-1:0];
      valid_d = 1'b1;
    end else if (xfer_w) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= SEED_NZ;
      coll_q  <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      coll_q  <= coll_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      lock_q  <= lock_d;
    end
  end

  assign state_o      = state_q;
  assign bit_o        = bit_w;
  assign word_o       = word_q;
  assign word_valid_o = valid_q;
  assign stall_o      = enable_i & ~load_i & stall_w;
  assign lockup_o     = lock_q;

endmodule

// File: tb/tb_lfsr_prng.sv
// Directed bench for lfsr_prng: 4-bit Fibonacci and Galois instances
// sharing stimulus, hand-computed state and word sequences.
module tb_lfsr_prng;

  logic       clk = 1'b0;
  logic       reset_i;
  logic       enable_i;
  logic       load_i;
  logic [3:0] seed_i;
  logic       word_ready_i;

  logic [3:0] f_state, g_state;
  logic       f_bit, g_bit;
  logic [3:0] f_word, g_word;
  logic       f_valid, g_valid;
  logic       f_stall, g_stall;
  logic       f_lock, g_lock;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  lfsr_prng #(
    .WIDTH(4), .TAPS(4'hC), .SEED(4'h1), .MODE(1'b0), .OUT_W(4)
  ) u_fib (
    .clk_i(clk), .reset_i(reset_i), .enable_i(enable_i),
    .load_i(load_i), .seed_i(seed_i), .state_o(f_state),
    .bit_o(f_bit), .word_o(f_word), .word_valid_o(f_valid),
    .word_ready_i(word_ready_i), .stall_o(f_stall),
    .lockup_o(f_lock)
  );

  lfsr_prng #(
    .WIDTH(4), .TAPS(4'hC), .SEED(4'h1), .MODE(1'b1), .OUT_W(4)
  ) u_gal (
    .clk_i(clk), .reset_i(reset_i), .enable_i(enable_i),
    .load_i(load_i), .seed_i(seed_i), .state_o(g_state),
    .bit_o(g_bit), .word_o(g_word), .word_valid_o(g_valid),
    .word_ready_i(word_ready_i), .stall_o(g_stall),
    .lockup_o(g_lock)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    enable_i = 1'b0;
    load_i = 1'b0;
    tick();
    reset_i = 1'b0;
  endtask

  logic [3:0] fib_seq [15];
  logic [3:0] gal_seq [15];

  initial begin
    fib_seq = '{4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5,
                4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};
    gal_seq = '{4'hC, 4'h6, 4'h3, 4'hD, 4'hA, 4'h5, 4'hE, 4'h7,
                4'hF, 4'hB, 4'h9, 4'h8, 4'h4, 4'h2, 4'h1};
    reset_i = 1'b1;
    enable_i = 1'b0;
    load_i = 1'b0;
    seed_i = 4'h0;
    word_ready_i = 1'b1;
    tick();
    tick();
    check("rst_state", f_state, 4'h1);
    check("rst_gstate", g_state, 4'h1);
    check("rst_valid", f_valid, 1'b0);
    check("rst_word", f_word, 4'h0);
    check("rst_lock", f_lock, 1'b0);
    check("rst_bit", f_bit, 1'b0);
    check("rst_gbit", g_bit, 1'b1);
    reset_i = 1'b0;

    // period, sequence and packing with ready held high
    enable_i = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      check($sformatf("fib_s%0d", k), f_state, fib_seq[k-1]);
      check($sformatf("gal_s%0d", k), g_state, gal_seq[k-1]);
      check($sformatf("val_%0d", k), f_valid, (k % 4) == 0);
      check($sformatf("stall_%0d", k), f_stall, 1'b0);
      if (k == 4) check("word1", f_word, 4'b0001);
      if (k == 4) check("gword1", g_word, 4'b1001);
      if (k == 8) check("word2", f_word, 4'b0011);
      if (k == 12) check("word3", f_word, 4'b0101);
    end

    // backpressure
    do_reset();
    word_ready_i = 1'b0;
    enable_i = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    check("bp_valid", f_valid, 1'b1);
    check("bp_word", f_word, 4'b0001);
    check("bp_st4", f_state, 4'h3);
    for (int k = 0; k < 3; k++) tick();
    check("bp_st7", f_state, 4'hA);
    check("bp_stall", f_stall, 1'b1);
    tick();
    tick();
    check("bp_frozen", f_state, 4'hA);
    check("bp_hold_w", f_word, 4'b0001);
    check("bp_hold_v", f_valid, 1'b1);
    check("bp_stall2", f_stall, 1'b1);
    enable_i = 1'b0;
    #1;
    check("bp_nostall_en0", f_stall, 1'b0);
    enable_i = 1'b1;
    word_ready_i = 1'b1;
    #1;
    check("bp_unstall", f_stall, 1'b0);
    tick();
    check("bp_st_go", f_state, 4'h5);
    check("bp_word2", f_word, 4'b0011);
    check("bp_valid2", f_valid, 1'b1);
    tick();
    check("bp_drain", f_valid, 1'b0);

    // zero-seed load with a pending word
    do_reset();
    word_ready_i = 1'b0;
    enable_i = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    load_i = 1'b1;
    seed_i = 4'h0;
    tick();
    check("zl_state", f_state, 4'h1);
    check("zl_lock", f_lock, 1'b1);
    check("zl_pend_v", f_valid, 1'b1);
    check("zl_pend_w", f_word, 4'b0001);
    load_i = 1'b0;
    enable_i = 1'b0;
    tick();
    check("zl_lock_off", f_lock, 1'b0);
    check("zl_hold", f_state, 4'h1);
    word_ready_i = 1'b1;
    enable_i = 1'b1;
    tick();
    check("zl_xfer", f_valid, 1'b0);
    tick();
    tick();
    check("zl_nv3", f_valid, 1'b0);
    tick();
    check("zl_v4", f_valid, 1'b1);
    check("zl_word", f_word, 4'b0001);

    // non-zero load ignores enable
    load_i = 1'b1;
    seed_i = 4'hD;
    tick();
    check("ld_state", f_state, 4'hD);
    check("ld_lock", f_lock, 1'b0);
    load_i = 1'b0;
    enable_i = 1'b0;
    tick();
    check("en0_hold", f_state, 4'hD);

    // async reset between edges, mid-word with a pending word
    word_ready_i = 1'b0;
    enable_i = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    check("ar_pre_v", f_valid, 1'b1);
    #2;
    reset_i = 1'b1;
    #1;
    check("ar_state", f_state, 4'h1);
    check("ar_valid", f_valid, 1'b0);
    check("ar_word", f_word, 4'h0);
    check("ar_gstate", g_state, 4'h1);
    tick();
    reset_i = 1'b0;
    word_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    check("ar_word1", f_word, 4'b0001);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
